sort_result_drain: RTL and testbench
====================================

// Module: sort_result_drain
// PURPOSE
//   Downstream stage of the sorter. On completion of a sort it reads all 2**L
//   words out of the sorter's memory over the Rd/RAddr/DataOut port, in address
//   order, and presents them as a valid/ready stream with the last word flagged.
//   It also checks the stream's order and reports a sticky error if the output is unsorted.
// PARAMETERS
//   N        16  data word width (matches sorter N)
//   L        4   address width; DEPTH = 2**L words drained per run
//   DESCEND  0   0: expected order ascending; 1: descending (order check only)
// PORTS
//   clk         in   1  single clock, all logic on rising edge
//   rst         in   1  synchronous, active-high reset
//   sort_done   in   1  sorter done; level or pulse, rising edge used
//   rd          out  1  read strobe to sorter Rd
//   raddr       out  L  read address to sorter RAddr
//   rdata       in   N  sorter DataOut; valid exactly 1 cycle after rd
//   m_valid     out  1  output word valid
//   m_ready     in   1  downstream accepts when m_valid&&m_ready
//   m_data      out  N  output word
//   m_last      out  1  high with word at address DEPTH-1
//   busy        out  1  high from drain start until drain_done
//   drain_done  out  1  one-cycle pulse after last word accepted
//   order_err   out  1  sticky; set when accepted word breaks expected order
// BEHAVIOUR
//   Reset: rd=0, raddr=0, m_valid=0, m_data=0, m_last=0, busy=0,
//     drain_done=0, order_err=0; FIFO emptied, in-flight read dropped, FSM->IDLE.
//   Reset mid-drain aborts the run; no partial completion is signalled.
//   sort_done edge detect: registered previous value; start = sort_done & ~prev.
//   FSM states:
//     IDLE : busy=0, rd=0. start -> READ; addr=0, order_err cleared, busy=1.
//     READ : issue rd=1, raddr=addr when credit ok; addr++ per issue.
//            After issuing addr DEPTH-1 -> FLUSH.
//     FLUSH: rd=0; wait until inflight=0, FIFO empty -> IDLE, drain_done=1 (1 cyc).
//   start while busy (READ/FLUSH) is ignored; a sort_done still high on return to
//     IDLE does not restart (edge only).
//   Buffer: 2-entry FIFO of {data,last}. inflight=1 in the cycle after rd.
//   Credit: issue allowed iff occ + inflight - pop < 2, pop = m_valid&&m_ready.
//     -> with m_ready held high, one word per cycle, no bubbles after first.
//   Latency: start cycle T -> rd at T+1 -> first m_valid at T+3 (rdata captured
//     at T+2 into FIFO, FIFO head registered). Total with m_ready=1:
//     drain_done at T+DEPTH+3.
//   m_data/m_last/m_valid hold stable while m_valid && !m_ready.
//   Order check on each pop: compare m_data with previously popped word
//     (unsigned); first word of a run is not checked. ASC: err if cur<prev;
//     DESC: err if cur>prev. Equal words are legal. Sets order_err next cycle.
//   Writes to sorter memory are never issued; rd is never high outside READ.
// TESTING
//   1. Load sorter via WrInit with 0..15 descending; run sort; m_ready=1 ->
//      stream 0,1,..,15, m_last on 15 only, order_err=0, drain_done once.
//   2. Same, m_ready toggling 1/0 each cycle -> identical 16 words, no drops or
//      duplicates, data stable across stall cycles, rd never >2 ahead of pops.
//   3. Drive rdata from a model with word 5 = 0x0000 among ascending data ->
//      order_err rises after word 5 accepted and stays high to next start.
//   4. Hold sort_done high for 40 cycles -> exactly one drain of 16 words;
//      second sort_done pulse mid-drain -> ignored, still 16 words total.
//   5. Assert rst after 7 words accepted -> next cycle m_valid=0, busy=0,
//      rd=0; new start drains from address 0.
//   6. All words equal 0xA5A5, DESCEND=0 and 1 -> order_err stays 0.

Source files
------------

// File: rtl/sort_result_drain.sv
// Drains 2**L sorted words from the sorter memory into a valid/ready stream,
// flags the last word and watches the stream for order violations.
module sort_result_drain #(
    parameter int N       = 16,
    parameter int L       = 4,
    parameter int DESCEND = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sort_done_i,
    output logic         rd_o,
    output logic [L-1:0] raddr_o,
    input  logic [N-1:0] rdata_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [N-1:0] m_data_o,
    output logic         m_last_o,
    output logic         busy_o,
    output logic         drain_done_o,
    output logic         order_err_o
);

    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_e;

    state_e       state_q;
    logic         done_prev_q;
    logic [L-1:0] addr_q;
    logic         busy_q;
    logic         drain_done_q;
    logic         order_err_q;
    logic         have_prev_q;
    logic [N-1:0] prev_q;

    logic         infl_q;
    logic         infl_last_q;
    logic [N-1:0] fifo_data_q [2];
    logic         fifo_last_q [2];
    logic         wptr_q;
    logic         rptr_q;
    logic [1:0]   occ_q;

    logic         start;
    logic         push;
    logic         pop;
    logic [2:0]   outstanding;
    logic         issue_ok;
    logic         fin_ok;
    logic         bad_order;

    assign start       = sort_done_i & ~done_prev_q;
    assign push        = infl_q;
    assign pop         = m_valid_o & m_ready_i;
    // Words already buffered or in flight, minus the one leaving this cycle
    assign outstanding = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue_ok    = outstanding < 3'd2;
    assign fin_ok      = !infl_q && (occ_q == 2'd0 || (occ_q == 2'd1 && pop));

    assign rd_o         = (state_q == READ) && issue_ok;
    assign raddr_o      = addr_q;
    assign m_valid_o    = occ_q != 2'd0;
    assign m_data_o     = fifo_data_q[rptr_q];
    assign m_last_o     = m_valid_o & fifo_last_q[rptr_q];
    assign busy_o       = busy_q;
    assign drain_done_o = drain_done_q;
    assign order_err_o  = order_err_q;

    always_comb begin
        bad_order = 1'b0;
        if (have_prev_q) begin
            if (DESCEND != 0) bad_order = m_data_o > prev_q;
            else              bad_order = m_data_o < prev_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            done_prev_q  <= 1'b0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            done_prev_q  <= sort_done_i;
            drain_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= READ;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_o) begin
                        addr_q <= addr_q + 1'b1;
                        if (addr_q == {L{1'b1}}) state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fin_ok) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        drain_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Order checker; cleared at each new run, sticky until then
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            order_err_q <= 1'b0;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
        end else if (state_q == IDLE && start) begin
            order_err_q <= 1'b0;
            have_prev_q <= 1'b0;
        end else if (pop) begin
            have_prev_q <= 1'b1;
            prev_q      <= m_data_o;
            if (bad_order) order_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            infl_q         <= 1'b0;
            infl_last_q    <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
            occ_q          <= 2'd0;
        end else begin
            infl_q      <= rd_o;
            infl_last_q <= rd_o && (addr_q == {L{1'b1}});
            if (push) begin
                fifo_data_q[wptr_q] <= rdata_i;
                fifo_last_q[wptr_q] <= infl_last_q;
                wptr_q              <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sort_result_drain.sv
// Directed bench for sort_result_drain: memory model, stream scoreboard,
// and literal latency/order-flag expectations; two instances (ASC and DESC).
module tb_sort_result_drain;
    localparam int N = 16;
    localparam int L = 4;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sd = 1'b0;
    logic mrdy = 1'b1;
    int   rdy_mode = 0;

    logic rd_a, rd_d, mv_a, mv_d, ml_a, ml_d;
    logic busy_a, busy_d, dd_a, dd_d, oe_a, oe_d;
    logic [L-1:0] ra_a, ra_d;
    logic [N-1:0] md_a, md_d;
    logic [N-1:0] rdat_a = '0;
    logic [N-1:0] rdat_d = '0;
    logic [N-1:0] mem [D];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    sort_result_drain #(.N(N), .L(L), .DESCEND(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .sort_done_i(sd),
        .rd_o(rd_a), .raddr_o(ra_a), .rdata_i(rdat_a),
        .m_valid_o(mv_a), .m_ready_i(mrdy), .m_data_o(md_a),
        .m_last_o(ml_a), .busy_o(busy_a), .drain_done_o(dd_a),
        .order_err_o(oe_a));

    sort_result_drain #(.N(N), .L(L), .DESCEND(1)) dut_d (
        .clk_i(clk), .rst_i(rst), .sort_done_i(sd),
        .rd_o(rd_d), .raddr_o(ra_d), .rdata_i(rdat_d),
        .m_valid_o(mv_d), .m_ready_i(mrdy), .m_data_o(md_d),
        .m_last_o(ml_d), .busy_o(busy_d), .drain_done_o(dd_d),
        .order_err_o(oe_d));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_a) rdat_a <= mem[ra_a];
        if (rd_d) rdat_d <= mem[ra_d];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard state
    int idx = 0, rds = 0, pops = 0, done_cnt = 0;
    int first_v = -1, done_cyc = 0, start_cyc = 0;
    logic err_a = 0, err_d = 0, stall = 0, hold_l = 0;
    logic [N-1:0] prevw = '0, hold_d = '0;
    bit kick = 0;

    always @(negedge clk) begin
        if (rst) begin
            idx = 0; rds = 0; pops = 0;
            err_a = 0; err_d = 0; stall = 0;
        end else begin
            if (kick) begin
                kick = 0;
                idx = 0; rds = 0; pops = 0;
                err_a = 0; err_d = 0; first_v = -1;
            end else begin
                chk("order_err_asc", int'(oe_a), int'(err_a));
                chk("order_err_desc", int'(oe_d), int'(err_d));
            end
            if (stall) begin
                chk("stall_valid", int'(mv_a), 1);
                chk("stall_data", int'(md_a), int'(hold_d));
                chk("stall_last", int'(ml_a), int'(hold_l));
            end
            if (mv_a && first_v < 0) first_v = cyc;
            if (rd_a) begin
                rds++;
                chk("raddr_order", int'(ra_a), rds - 1);
                chk("rd_while_busy", int'(busy_a), 1);
            end
            if (mv_a && mrdy) begin
                chk("pop_in_range", int'(idx < D), 1);
                if (idx < D) begin
                    chk("word", int'(md_a), int'(mem[idx]));
                    chk("word_desc_inst", int'(md_d), int'(mem[idx]));
                    chk("last_flag", int'(ml_a), int'(idx == D - 1));
                end
                if (idx > 0) begin
                    if (md_a < prevw) err_a = 1;
                    if (md_a > prevw) err_d = 1;
                end
                prevw = md_a;
                idx++;
                pops++;
            end
            if (rd_a) chk("credit_limit", int'(rds - pops <= 2), 1);
            stall = mv_a && !mrdy;
            hold_d = md_a;
            hold_l = ml_a;
            if (dd_a) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_all", idx, D);
                chk("done_desc_inst", int'(dd_d), 1);
                chk("done_not_busy", int'(busy_a), 0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) mrdy = ~mrdy;
            else               mrdy = 1'b1;
        end
    end

    task automatic kick_start();
        @(posedge clk);
        #1;
        sd = 1'b1;
        kick = 1;
        start_cyc = cyc;
    endtask

    task automatic pulse_start();
        kick_start();
        @(posedge clk);
        #1;
        sd = 1'b0;
    endtask

    task automatic wait_done();
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_cnt > c0) break;
        end
        chk("done_timeout", int'(done_cnt > c0), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < D; i++) mem[i] = N'(i);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(mv_a), 0);
        chk("rst_data", int'(md_a), 0);
        chk("rst_last", int'(ml_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_rd", int'(rd_a), 0);
        chk("rst_raddr", int'(ra_a), 0);
        chk("rst_done", int'(dd_a), 0);
        chk("rst_err", int'(oe_a), 0);

        // 1: sorted 0..15, ready held high
        c0 = done_cnt;
        pulse_start();
        wait_done();
        chk("t1_first_valid_lat", first_v - start_cyc, 3);
        chk("t1_done_lat", done_cyc - start_cyc, 19);
        chk("t1_done_once", done_cnt - c0, 1);
        chk("t1_words", pops, 16);
        chk("t1_err", int'(oe_a), 0);

        // 2: ready toggling
        rdy_mode = 1;
        pulse_start();
        wait_done();
        rdy_mode = 0;
        chk("t2_words", pops, 16);
        chk("t2_err", int'(oe_a), 0);

        // 3: zero at word 5 among ascending data
        for (int i = 0; i < D; i++) mem[i] = N'(3 * i + 1);
        mem[5] = '0;
        pulse_start();
        wait_done();
        chk("t3_err_asc", int'(oe_a), 1);
        chk("t3_err_desc", int'(oe_d), 1);
        repeat (4) @(negedge clk);
        chk("t3_err_sticky", int'(oe_a), 1);

        // 4: sort_done held 40 cycles, then a second pulse mid-drain
        for (int i = 0; i < D; i++) mem[i] = N'(16'h0100 + i);
        c0 = done_cnt;
        kick_start();
        repeat (40) @(posedge clk);
        #1;
        sd = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_hold_one_drain", done_cnt - c0, 1);
        chk("t4_hold_words", pops, 16);
        chk("t4_hold_idle", int'(busy_a), 0);
        c0 = done_cnt;
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        sd = 1'b1;
        @(posedge clk);
        #1;
        sd = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        chk("t4_mid_one_drain", done_cnt - c0, 1);
        chk("t4_mid_words", pops, 16);

        // 5: reset after 7 accepted words
        c0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pops >= 7) break;
        end
        chk("t5_reached_7", int'(pops >= 7), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_valid_low", int'(mv_a), 0);
        chk("t5_busy_low", int'(busy_a), 0);
        chk("t5_rd_low", int'(rd_a), 0);
        chk("t5_no_done", done_cnt - c0, 0);
        pulse_start();
        wait_done();
        chk("t5_rerun_words", pops, 16);

        // 6: all words equal
        for (int i = 0; i < D; i++) mem[i] = 16'hA5A5;
        rdy_mode = 1;
        pulse_start();
        wait_done();
        rdy_mode = 0;
        chk("t6_err_asc", int'(oe_a), 0);
        chk("t6_err_desc", int'(oe_d), 0);
        chk("t6_words", pops, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
